// File: rtl/dm_sbus_arbiter.sv
// System-bus arbiter for debug-module masters with an in-order outstanding-ID FIFO for response routing.
// Define DM_SBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dm_sbus_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   r_valid_o,
  output logic                                 r_err_o,
  output logic                                 r_other_err_o,
  output logic [DATA_WIDTH-1:0]                r_rdata_o,
  output logic                                 master_req_o,
  output logic [ADDR_WIDTH-1:0]                master_add_o,
  output logic                                 master_we_o,
  output logic [DATA_WIDTH-1:0]                master_wdata_o,
  output logic [DATA_WIDTH/8-1:0]              master_be_o,
  input  logic                                 master_gnt_i,
  input  logic                                 master_r_valid_i,
  input  logic                                 master_r_err_i,
  input  logic                                 master_r_other_err_i,
  input  logic [DATA_WIDTH-1:0]                master_r_rdata_i,
  output logic                                 spurious_rsp_o,
  output logic                                 busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] head;
  logic             any_req;
  logic             found;
  logic             full;
  logic             grant;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

`ifndef DM_SBUS_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction
`endif

  // Arbitration: first requester found scanning from the priority start point
  always_comb begin
    arb_idx = '0;
    found   = 1'b0;
    cand    = '0;
    any_req = |req_i;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef DM_SBUS_ARB_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
`endif
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign full = (count == CNT_W'(MAX_OUTSTANDING));

  // Full FIFO blocks the request even if a response pops in the same cycle
  always_comb begin
    state_nxt    = state;
    winner       = arb_idx;
    master_req_o = 1'b0;
    case (state)
      IDLE: begin
        winner       = arb_idx;
        master_req_o = any_req & ~full;
        if (master_req_o && !master_gnt_i) state_nxt = LOCKED;
      end
      LOCKED: begin
        winner       = lock_idx;
        master_req_o = req_i[lock_idx] & ~full;
        if (master_gnt_i || !req_i[lock_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant          = master_req_o & master_gnt_i;
  assign gnt_o          = grant ? (NUM_REQ'(1) << winner) : '0;
  assign master_add_o   = master_req_o ? addr_i[winner]  : '0;
  assign master_we_o    = master_req_o ? we_i[winner]    : 1'b0;
  assign master_wdata_o = master_req_o ? wdata_i[winner] : '0;
  assign master_be_o    = master_req_o ? be_i[winner]    : '0;

  assign pop           = master_r_valid_i & (count != '0);
  assign head          = fifo_mem[rd_ptr];
  assign r_valid_o     = pop ? (NUM_REQ'(1) << head) : '0;
  assign r_rdata_o     = pop ? master_r_rdata_i : '0;
  assign r_err_o       = pop & master_r_err_i;
  assign r_other_err_o = pop & master_r_other_err_i;
  assign busy_o        = (count != '0) | master_req_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      lock_idx       <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      spurious_rsp_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOCKED) lock_idx <= winner;
      if (grant) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (master_r_valid_i && count == '0) spurious_rsp_o <= 1'b1;
    end
  end

`ifndef DM_SBUS_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)      rr_ptr <= '0;
    else if (grant) rr_ptr <= idx_inc(winner);
  end
`endif

  // FIFO storage needs no reset: pointers and count gate every read
  always_ff @(posedge clk_i) begin
    if (grant) fifo_mem[wr_ptr] <= winner;
  end

endmodule

// File: doc/dm_sbus_arbiter.md
Name: dm_sbus_arbiter

Overview:
- Shares the single system-bus master port (req/gnt/rvalid handshake) between NUM_REQ requesters: SBA master (index 0) and other debug-side masters, e.g. a program-buffer/abstract-command memory accessor (index 1).
- Arbitrates requests and holds the selection stable until grant.
- Tracks outstanding transactions in an in-order ID FIFO so each rvalid/rdata/error response returns to the requester that issued it.
- Sits between the debug-module masters and the SoC bus interconnect.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width. Byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (1..8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  per-requester request
- addr_i  in  NUM_REQ x ADDR_WIDTH  per-requester address
- we_i  in  NUM_REQ  per-requester write enable
- wdata_i  in  NUM_REQ x DATA_WIDTH  per-requester write data
- be_i  in  NUM_REQ x DATA_WIDTH/8  per-requester byte enables
- gnt_o  out  NUM_REQ  per-requester grant
- r_valid_o  out  NUM_REQ  per-requester response valid
- r_err_o  out  1  response bus error (qualified by r_valid_o)
- r_other_err_o  out  1  response other error (qualified by r_valid_o)
- r_rdata_o  out  DATA_WIDTH  response read data, broadcast
- master_req_o  out  1  bus request
- master_add_o  out  ADDR_WIDTH  bus address
- master_we_o  out  1  bus write enable
- master_wdata_o  out  DATA_WIDTH  bus write data
- master_be_o  out  DATA_WIDTH/8  bus byte enables
- master_gnt_i  in  1  bus grant
- master_r_valid_i  in  1  bus response valid
- master_r_err_i  in  1  bus error
- master_r_other_err_i  in  1  bus other error
- master_r_rdata_i  in  DATA_WIDTH  bus read data
- spurious_rsp_o  out  1  sticky flag: rvalid received with no outstanding transaction
- busy_o  out  1  outstanding count != 0 or master_req_o high

Behaviour:
- Reset (rst_i high at clk_i edge):
  - Outstanding count = 0; FIFO pointers = 0.
  - Round-robin pointer = 0; lock = 0; spurious_rsp_o = 0.
  - All outputs are then 0: master_req_o, gnt_o, r_valid_o and all data/address outputs.
  - Responses pending at reset are dropped; rvalid arriving after reset with count 0 sets spurious_rsp_o.
- States: IDLE (no lock) and LOCKED (selection held).
- In IDLE, if any req_i is set and the FIFO is not full:
  - Select a winner combinationally, round-robin starting from the pointer.
  - Drive master_req_o=1 and mux the winner's addr/we/wdata/be the same cycle (zero-latency request path).
  - If master_gnt_i=0, register the winner and enter LOCKED.
- In LOCKED:
  - Selection is frozen to the registered winner regardless of other req_i.
  - Return to IDLE on master_gnt_i=1.
  - Requesters must hold req_i and payload stable until gnt_o. If the locked requester drops req_i, master_req_o still follows req_i (0) and the lock is released.
- gnt_o[winner] = master_gnt_i & master_req_o; at most one gnt_o bit high per cycle.
- On grant (master_req_o & master_gnt_i):
  - Push winner index into the FIFO; count +1.
  - Round-robin pointer = winner+1 mod NUM_REQ.
- FIFO full (count==MAX_OUTSTANDING): master_req_o=0, no new grant. This holds even if a response pops the FIFO in the same cycle. Grant resumes the next cycle.
- On master_r_valid_i with count>0:
  - Pop the head; r_valid_o[head]=1 in the same cycle (combinational).
  - r_rdata_o, r_err_o and r_other_err_o pass through.
  - count -1.
- Grant and response in the same cycle with count < MAX: push and pop both occur; count unchanged.
- master_r_valid_i with count==0: ignored (no r_valid_o); spurious_rsp_o set, cleared only by reset.
- Pointers wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING+1).

Optional Feature:
- Macro DM_SBUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (SBA always preferred); round-robin pointer not implemented. Lock, FIFO and all other behaviour are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single read: req_i=01, addr 0x10, gnt=1; rvalid 2 cycles later with rdata 0x12345678 -> gnt_o=01 same cycle; r_valid_o=01 with r_rdata_o=0x12345678; busy_o back to 0.
- Contention: req_i=11 held for 4 grants with gnt=1 -> grant order 0,1,0,1 (with the macro: 0,0,0,0).
- Lock: req_i=01, gnt=0 for 3 cycles, req_i[1] rises in cycle 2 -> master_add_o stays on requester 0 until gnt; the next grant goes to 1.
- Full FIFO: MAX_OUTSTANDING=2, two grants with no rvalid -> master_req_o=0 with req pending; rvalid in cycle N -> request re-asserts in cycle N+1.
- Response routing: grants to 1 then 0, two rvalids with err on the first -> r_valid_o=10 with r_err_o=1, then r_valid_o=01 with r_err_o=0.
- Reset and spurious: reset with 1 outstanding, then rvalid -> no r_valid_o, spurious_rsp_o=1.
